// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor: 2-bit counter encodings
// and the saturating counter update rule.
package bp_pkg;

  localparam logic [1:0] SNT = 2'd0;
  localparam logic [1:0] WNT = 2'd1;
  localparam logic [1:0] WT  = 2'd2;
  localparam logic [1:0] ST  = 2'd3;

  localparam logic [1:0] BHT_RESET_STATE = WNT;

  // Increment toward ST on taken, decrement toward SNT on not-taken, saturating.
  function automatic logic [1:0] sat_update(input logic [1:0] state, input logic taken);
    logic [1:0] nxt;
    if (taken) begin
      nxt = (state == ST) ? ST : state + 2'd1;
    end else begin
      nxt = (state == SNT) ? SNT : state - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bht_table.sv
// Branch history table: array of 2-bit saturating counters with one
// combinational read port and one synchronous read-modify-write port.
module bht_table
  import bp_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int INDEX_W = $clog2(ENTRIES)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INDEX_W-1:0] rd_idx_i,
  output logic [1:0]         rd_state_o,
  input  logic               wr_en_i,
  input  logic [INDEX_W-1:0] wr_idx_i,
  input  logic               wr_taken_i
);

  logic [1:0] cnt_q [ENTRIES];

  // No bypass: a read of the entry being written returns the old value.
  assign rd_state_o = cnt_q[rd_idx_i];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        cnt_q[i] <= BHT_RESET_STATE;
      end
    end else if (wr_en_i) begin
      cnt_q[wr_idx_i] <= sat_update(cnt_q[wr_idx_i], wr_taken_i);
    end
  end

endmodule

// File: rtl/branch_predictor_bht.sv
// Bimodal branch predictor: predicts in ID, carries the prediction through an
// ID->EX register, resolves in EX and trains the counter table.
module branch_predictor_bht
  import bp_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int INDEX_W = $clog2(ENTRIES)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ID_valid,
  input  logic        ID_is_branch,
  input  logic [31:0] ID_pc,
  output logic        ID_pred_taken,
  input  logic        stall,
  input  logic        flush,
  input  logic        EX_branch_taken,
  output logic        EX_feedback_valid,
  output logic        EX_prediction_incorrect
);

  logic [INDEX_W-1:0] id_idx;
  logic [1:0]         id_state;
  logic               unused_pc;

  logic               ex_valid_q, ex_valid_d;
  logic [INDEX_W-1:0] ex_idx_q, ex_idx_d;
  logic               ex_pred_q, ex_pred_d;

  assign id_idx    = ID_pc[INDEX_W+1:2];
  assign unused_pc = ^{ID_pc[31:INDEX_W+2], ID_pc[1:0]};

  bht_table #(
    .ENTRIES (ENTRIES),
    .INDEX_W (INDEX_W)
  ) u_table (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_idx_i   (id_idx),
    .rd_state_o (id_state),
    .wr_en_i    (EX_feedback_valid),
    .wr_idx_i   (ex_idx_q),
    .wr_taken_i (EX_branch_taken)
  );

  assign ID_pred_taken = ID_valid & ID_is_branch & id_state[1];

  // stall freezes the EX slot, so a held branch resolves only once it moves on.
  assign EX_feedback_valid       = ex_valid_q & ~stall;
  assign EX_prediction_incorrect = EX_feedback_valid & (ex_pred_q ^ EX_branch_taken);

  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_idx_d   = ex_idx_q;
    ex_pred_d  = ex_pred_q;
    if (!stall) begin
      if (flush) begin
        ex_valid_d = 1'b0;
      end else begin
        ex_valid_d = ID_valid & ID_is_branch;
        ex_idx_d   = id_idx;
        ex_pred_d  = ID_pred_taken;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid_q <= 1'b0;
      ex_idx_q   <= '0;
      ex_pred_q  <= 1'b0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_idx_q   <= ex_idx_d;
      ex_pred_q  <= ex_pred_d;
    end
  end

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Directed bench for branch_predictor_bht: a reference counter table plus a
// queue of in-flight {index, prediction} entries checked when EX resolves.
module tb_branch_predictor_bht;

  localparam int ENTRIES = 16;
  localparam int INDEX_W = $clog2(ENTRIES);
  localparam int W       = INDEX_W + 1;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic        id_is_branch;
  logic [31:0] id_pc;
  logic        id_pred_taken;
  logic        stall;
  logic        flush;
  logic        ex_branch_taken;
  logic        ex_feedback_valid;
  logic        ex_prediction_incorrect;

  branch_predictor_bht #(
    .ENTRIES (ENTRIES),
    .INDEX_W (INDEX_W)
  ) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .ID_valid                (id_valid),
    .ID_is_branch            (id_is_branch),
    .ID_pc                   (id_pc),
    .ID_pred_taken           (id_pred_taken),
    .stall                   (stall),
    .flush                   (flush),
    .EX_branch_taken         (ex_branch_taken),
    .EX_feedback_valid       (ex_feedback_valid),
    .EX_prediction_incorrect (ex_prediction_incorrect)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state
  logic [1:0]   m_tab [ENTRIES];
  logic [W-1:0] exp_q [$];
  int tests_run;
  int tests_failed;
  int fb_seen;
  int inc_seen;
  int m_fb;
  int m_inc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    fb_seen  = 0;
    inc_seen = 0;
    m_fb     = 0;
    m_inc    = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n           = 1'b0;
    id_valid        = 1'b0;
    id_is_branch    = 1'b0;
    id_pc           = '0;
    stall           = 1'b0;
    flush           = 1'b0;
    ex_branch_taken = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < ENTRIES; i++) m_tab[i] = 2'd1;
    exp_q.delete();
    clear_counts();
  endtask

  // One cycle: drive at negedge, check combinational outputs, advance the model.
  task automatic step(input logic v, input logic br, input logic [31:0] pc,
                      input logic st, input logic fl, input logic tk);
    logic [INDEX_W-1:0] idx;
    logic               e_pred;
    logic               e_fb;
    logic               e_inc;
    logic [W-1:0]       head;
    logic [1:0]         cur;
    @(negedge clk);
    id_valid        = v;
    id_is_branch    = br;
    id_pc           = pc;
    stall           = st;
    flush           = fl;
    ex_branch_taken = tk;
    #1;
    idx    = pc[INDEX_W+1:2];
    e_pred = v & br & m_tab[idx][1];
    e_fb   = (exp_q.size() != 0) && !st;
    e_inc  = 1'b0;
    head   = '0;
    if (e_fb) begin
      head  = exp_q.pop_front();
      e_inc = head[0] ^ tk;
    end
    check("id_pred_taken", {31'd0, id_pred_taken}, {31'd0, e_pred});
    check("ex_feedback_valid", {31'd0, ex_feedback_valid}, {31'd0, e_fb});
    check("ex_prediction_incorrect", {31'd0, ex_prediction_incorrect}, {31'd0, e_inc});
    if (ex_feedback_valid) fb_seen++;
    if (ex_prediction_incorrect) inc_seen++;
    if (e_fb) begin
      m_fb++;
      if (e_inc) m_inc++;
      cur = m_tab[head[W-1:1]];
      if (tk && cur != 2'd3) cur = cur + 2'd1;
      else if (!tk && cur != 2'd0) cur = cur - 2'd1;
      m_tab[head[W-1:1]] = cur;
    end
    if (!st && !fl && v && br) exp_q.push_back({idx, e_pred});
  endtask

  task automatic idle(input logic tk);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, tk);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    clear_counts();

    // Reset defaults: not-taken prediction everywhere, first taken resolution mispredicts
    do_reset();
    idle(1'b0);
    step(1'b1, 1'b1, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
    idle(1'b1);
    check("reset_first_fb_count", fb_seen, 1);
    check("reset_first_inc_count", inc_seen, 1);
    step(1'b1, 1'b1, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    step(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0);
    idle(1'b0);

    // Saturation at PC 0x40: four taken then two not-taken
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 32'h0000_0040, 1'b0, 1'b0, 1'b0);
      idle(1'b1);
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 32'h0000_0040, 1'b0, 1'b0, 1'b0);
      idle(1'b0);
    end
    step(1'b1, 1'b1, 32'h0000_0040, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    check("sat_fb_count", fb_seen, 7);
    check("sat_inc_count", inc_seen, m_inc);

    // Stall while EX holds a branch: one pulse, one table update
    do_reset();
    step(1'b1, 1'b1, 32'h0000_0080, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 32'h0000_0084, 1'b1, 1'b0, 1'b1);
    check("stall_no_fb", fb_seen, 0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    idle(1'b1);
    check("stall_single_fb", fb_seen, 1);
    step(1'b1, 1'b1, 32'h0000_0080, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    step(1'b1, 1'b1, 32'h0000_0080, 1'b0, 1'b0, 1'b0);
    idle(1'b0);

    // Flush alone squashes; flush with stall keeps the EX branch
    do_reset();
    step(1'b1, 1'b1, 32'h0000_0084, 1'b0, 1'b1, 1'b0);
    idle(1'b1);
    check("flush_no_fb", fb_seen, 0);
    step(1'b1, 1'b1, 32'h0000_0084, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h0000_0088, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 32'h0000_0088, 1'b1, 1'b1, 1'b1);
    check("flush_stall_hold", fb_seen, 0);
    idle(1'b1);
    check("flush_stall_once", fb_seen, 1);
    step(1'b1, 1'b1, 32'h0000_0084, 1'b0, 1'b0, 1'b0);
    idle(1'b1);

    // Aliasing 0x000/0x040 with same-cycle train and read
    do_reset();
    step(1'b1, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h0000_0040, 1'b0, 1'b0, 1'b1);
    idle(1'b1);
    step(1'b1, 1'b1, 32'h0000_0040, 1'b0, 1'b0, 1'b0);
    idle(1'b1);
    step(1'b1, 1'b1, 32'h1234_5000, 1'b0, 1'b0, 1'b0);
    idle(1'b0);

    // Non-branch instructions leave everything alone
    clear_counts();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, {$urandom_range(32'hFFFF, 0), 16'h0}, 1'b0, 1'b0,
           1'($urandom_range(1, 0)));
    end
    check("nonbranch_no_fb", fb_seen, 0);
    for (int i = 0; i < ENTRIES; i++) begin
      step(1'b1, 1'b1, 32'(i) << 2, 1'b0, 1'b1, 1'b0);
    end

    // Reset mid-operation discards the pending branch
    step(1'b1, 1'b1, 32'h0000_0044, 1'b0, 1'b0, 1'b0);
    do_reset();
    idle(1'b1);
    check("midreset_no_fb", fb_seen, 0);

    // Mixed random traffic against the reference model
    clear_counts();
    for (int i = 0; i < 200; i++) begin
      step(1'($urandom_range(1, 0)), 1'($urandom_range(3, 0) != 0),
           32'($urandom_range(63, 0)) << 2, 1'($urandom_range(3, 0) == 0),
           1'($urandom_range(7, 0) == 0), 1'($urandom_range(1, 0)));
    end
    check("random_fb_count", fb_seen, m_fb);
    check("random_inc_count", inc_seen, m_inc);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
